// File: rtl/sprite_pal_pkg.sv
// Shared types and constants for the sprite palette bank: colour struct,
// the built-in default palette and the fade engine state encoding.
package sprite_pal_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      FADE_IDLE = 2'd0,
      FADE_OUT  = 2'd1,
      FADE_DARK = 2'd2,
      FADE_IN   = 2'd3
   } fade_state_e;

   // Entry 0 sits in the rightmost slot; entry 2 is the reference colour 0x875.
   localparam rgb_t [15:0] DEFAULT_PAL = {
      12'h963, 12'h25A, 12'h5A2, 12'hA52, 12'hCCC, 12'h444, 12'h888, 12'hF0F,
      12'h0FF, 12'hFF0, 12'h00F, 12'h0F0, 12'hF00, 12'h875, 12'hFFF, 12'h000
   };

endpackage

// File: rtl/sprite_pal_fade.sv
// Frame-driven global brightness engine: fade state machine, frame tick
// divider and the brightness level register.
module sprite_pal_fade
   import sprite_pal_pkg::*;
#(
   parameter int FADE_W    = 4,
   parameter int FADE_STEP = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_tick_i,
   input  logic              fade_out_req_i,
   input  logic              fade_in_req_i,
   output logic [FADE_W-1:0] fade_level_o,
   output logic              fade_busy_o
);

   localparam int                TICK_W    = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
   localparam logic [FADE_W-1:0] LVL_MAX   = {FADE_W{1'b1}};
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FADE_STEP - 1);

   fade_state_e       state_r, state_s;
   logic [FADE_W-1:0] level_r, level_s;
   logic [TICK_W-1:0] tick_r, tick_s;
   logic              busy_r;

   // Next state: an opposite request reverses direction, which also resolves simultaneous requests
   always_comb begin
      state_s = state_r;
      level_s = level_r;
      tick_s  = tick_r;
      case (state_r)
         FADE_IDLE: begin
            if (fade_out_req_i) state_s = FADE_OUT;
            else                state_s = FADE_IDLE;
         end
         FADE_DARK: begin
            if (fade_in_req_i) state_s = FADE_IN;
            else               state_s = FADE_DARK;
         end
         FADE_OUT: begin
            if (fade_in_req_i) begin
               state_s = FADE_IN;
            end else if (frame_tick_i) begin
               if (tick_r == TICK_LAST) begin
                  tick_s  = {TICK_W{1'b0}};
                  level_s = level_r - FADE_W'(1);
                  if (level_r == FADE_W'(1)) state_s = FADE_DARK;
                  else                       state_s = FADE_OUT;
               end else begin
                  tick_s = tick_r + TICK_W'(1);
               end
            end else begin
               state_s = FADE_OUT;
            end
         end
         FADE_IN: begin
            if (fade_out_req_i) begin
               state_s = FADE_OUT;
            end else if (frame_tick_i) begin
               if (tick_r == TICK_LAST) begin
                  tick_s  = {TICK_W{1'b0}};
                  level_s = level_r + FADE_W'(1);
                  if (level_r == LVL_MAX - FADE_W'(1)) state_s = FADE_IDLE;
                  else                                 state_s = FADE_IN;
               end else begin
                  tick_s = tick_r + TICK_W'(1);
               end
            end else begin
               state_s = FADE_IN;
            end
         end
         default: begin
            state_s = FADE_IDLE;
            level_s = LVL_MAX;
         end
      endcase
      if (state_s != state_r) tick_s = {TICK_W{1'b0}};
      else                    tick_s = tick_s;
   end

   // State, level, divider and busy flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FADE_IDLE;
         level_r <= LVL_MAX;
         tick_r  <= {TICK_W{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         level_r <= level_s;
         tick_r  <= tick_s;
         busy_r  <= (state_s == FADE_OUT) || (state_s == FADE_IN);
      end
   end

   assign fade_level_o = level_r;
   assign fade_busy_o  = busy_r;

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-palette sprite colour lookup with 2-cycle read pipeline, write-through
// forwarding and global fade. Optional macro SPRITE_PAL_DEFAULT_LOAD_EN adds a
// post-reset loader that fills every palette from DEFAULT_PAL.
module sprite_palette_bank
   import sprite_pal_pkg::*;
#(
   parameter int IDX_W     = 4,
   parameter int COLOR_W   = 4,
   parameter int NUM_PAL   = 4,
   parameter int FADE_W    = 4,
   parameter int FADE_STEP = 2,
   parameter int PS_W      = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rd_valid_i,
   input  logic [PS_W-1:0]      rd_pal_i,
   input  logic [IDX_W-1:0]     rd_idx_i,
   input  logic                 wr_en_i,
   input  logic [PS_W-1:0]      wr_pal_i,
   input  logic [IDX_W-1:0]     wr_idx_i,
   input  logic [3*COLOR_W-1:0] wr_rgb_i,
   input  logic                 frame_tick_i,
   input  logic                 fade_out_req_i,
   input  logic                 fade_in_req_i,
   output logic [COLOR_W-1:0]   red_o,
   output logic [COLOR_W-1:0]   green_o,
   output logic [COLOR_W-1:0]   blue_o,
   output logic                 transparent_o,
   output logic                 valid_o,
   output logic [FADE_W-1:0]    fade_level_o,
   output logic                 fade_busy_o,
   output logic                 init_busy_o
);

   localparam int RGB_W  = 3 * COLOR_W;
   localparam int ADDR_W = PS_W + IDX_W;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [RGB_W-1:0]   mem [DEPTH];
   logic               s1_valid_r;
   logic [PS_W-1:0]    s1_pal_r;
   logic [IDX_W-1:0]   s1_idx_r;
   logic               wr_ok_s, rd_ok_s, fwd_s, init_busy_s;
   logic [RGB_W-1:0]   col_s;
   logic [FADE_W-1:0]  level_s;
   logic [COLOR_W-1:0] red_r, green_r, blue_r;
   logic               trans_r, valid_r;

   function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                input logic [FADE_W-1:0]  lvl);
      logic [COLOR_W+FADE_W-1:0] prod;
      prod = (COLOR_W+FADE_W)'(c) * (COLOR_W+FADE_W)'({1'b0, lvl} + (FADE_W+1)'(1));
      return prod[COLOR_W+FADE_W-1:FADE_W];
   endfunction

   sprite_pal_fade #(.FADE_W(FADE_W), .FADE_STEP(FADE_STEP)) u_fade (
      .clk            (clk),
      .rst_n          (rst_n),
      .frame_tick_i   (frame_tick_i),
      .fade_out_req_i (fade_out_req_i),
      .fade_in_req_i  (fade_in_req_i),
      .fade_level_o   (level_s),
      .fade_busy_o    (fade_busy_o)
   );

`ifdef SPRITE_PAL_DEFAULT_LOAD_EN
   localparam int LOAD_N = NUM_PAL * (2 ** IDX_W);
   logic              init_busy_r;
   logic [ADDR_W-1:0] init_cnt_r;

   // Loader sequencer: one entry per cycle from reset release until every palette is filled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_busy_r <= 1'b1;
         init_cnt_r  <= {ADDR_W{1'b0}};
      end else if (init_busy_r) begin
         if (int'(init_cnt_r) == LOAD_N - 1) init_busy_r <= 1'b0;
         init_cnt_r <= init_cnt_r + ADDR_W'(1);
      end
   end
   assign init_busy_s = init_busy_r;
`else
   assign init_busy_s = 1'b0;
`endif

   assign wr_ok_s = wr_en_i && (int'(wr_pal_i) < NUM_PAL);

   // Palette RAM; the loader write comes last so it wins an address collision
   always_ff @(posedge clk) begin
      if (wr_ok_s) mem[{wr_pal_i, wr_idx_i}] <= wr_rgb_i;
`ifdef SPRITE_PAL_DEFAULT_LOAD_EN
      if (init_busy_r) mem[init_cnt_r] <= RGB_W'(DEFAULT_PAL[init_cnt_r[3:0]]);
`endif
   end

   // Stage-2 colour fetch with write-through forwarding
   always_comb begin
      rd_ok_s = int'(s1_pal_r) < NUM_PAL;
      fwd_s   = wr_ok_s && (wr_pal_i == s1_pal_r) && (wr_idx_i == s1_idx_r);
      if (!rd_ok_s || init_busy_s) col_s = {RGB_W{1'b0}};
      else if (fwd_s)              col_s = wr_rgb_i;
      else                         col_s = mem[{s1_pal_r, s1_idx_r}];
   end

   // Request stage and output stage; colour outputs hold between valid lookups
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_pal_r   <= {PS_W{1'b0}};
         s1_idx_r   <= {IDX_W{1'b0}};
         valid_r    <= 1'b0;
         red_r      <= {COLOR_W{1'b0}};
         green_r    <= {COLOR_W{1'b0}};
         blue_r     <= {COLOR_W{1'b0}};
         trans_r    <= 1'b0;
      end else begin
         s1_valid_r <= rd_valid_i;
         s1_pal_r   <= rd_pal_i;
         s1_idx_r   <= rd_idx_i;
         valid_r    <= s1_valid_r;
         if (s1_valid_r) begin
            red_r   <= scale(col_s[RGB_W-1 -: COLOR_W], level_s);
            green_r <= scale(col_s[2*COLOR_W-1 -: COLOR_W], level_s);
            blue_r  <= scale(col_s[COLOR_W-1:0], level_s);
            trans_r <= rd_ok_s && (s1_idx_r == {IDX_W{1'b0}});
         end
      end
   end

   assign red_o         = red_r;
   assign green_o       = green_r;
   assign blue_o        = blue_r;
   assign transparent_o = trans_r;
   assign valid_o       = valid_r;
   assign fade_level_o  = level_s;
   assign init_busy_o   = init_busy_s;

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Runtime-writable multi-palette colour lookup for sprite rendering. Converts a per-pixel palette index plus palette select into RGB.
- Adds a registered read pipeline, transparency flag, write-through forwarding and a frame-driven global fade engine.
- Sits between the sprite ROM/index fetch and the VGA colour mux. One instance serves all sprites, selected by pal_sel (e.g. facing direction, damage flash).

Parameters:
- IDX_W, 4: palette index width; 2**IDX_W entries per palette.
- COLOR_W, 4: bits per colour channel.
- NUM_PAL, 4: number of palettes; pal_sel width is $clog2(NUM_PAL), minimum 1.
- FADE_W, 4: brightness level width; LVL_MAX = 2**FADE_W - 1.
- FADE_STEP, 2: frame_tick pulses per one-level fade step, ≥1.

Ports:
- Clk  in  1  system/pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- rd_valid_i  in  1  lookup request this cycle.
- rd_pal_i  in  PS_W  palette select.
- rd_idx_i  in  IDX_W  colour index.
- wr_en_i  in  1  palette write strobe.
- wr_pal_i  in  PS_W  palette to write.
- wr_idx_i  in  IDX_W  entry to write.
- wr_rgb_i  in  3*COLOR_W  {r,g,b} data.
- frame_tick_i  in  1  one-cycle pulse per frame (vsync edge).
- fade_out_req_i  in  1  start fade to black.
- fade_in_req_i  in  1  start fade to full brightness.
- red_o, green_o, blue_o  out  COLOR_W each  faded colour.
- transparent_o  out  1  index was 0.
- valid_o  out  1  outputs correspond to a request.
- fade_level_o  out  FADE_W  current brightness.
- fade_busy_o  out  1  FADE_OUT or FADE_IN active.
- init_busy_o  out  1  default loader active; tied 0 without the optional feature.

Behaviour:
- Reset: all outputs 0 except fade_level_o = LVL_MAX. FSM → IDLE, pipeline valids cleared. Palette RAM is not reset; contents are undefined until written, unless the optional feature is enabled.
- Latency is 2 cycles. Stage 1 registers the request. Stage 2 does the RAM read and the scale, then registers the outputs. valid_o = rd_valid_i delayed by 2; full throughput, one lookup per cycle.
- Colour outputs and transparent_o are held when valid_o = 0.
- transparent_o = (idx == 0) for the request; colour is still produced.
- rd_pal_i ≥ NUM_PAL: colour 0, transparent_o 0, valid_o 1.
- Writes take 1 cycle and have no handshake. wr_pal_i ≥ NUM_PAL is ignored.
- A stage-2 read hitting the same {pal, idx} being written in that cycle returns wr_rgb_i (write-through forwarding).
- Scaling per channel: out = (c * (level+1)) >> FADE_W, using a COLOR_W+FADE_W intermediate. level = LVL_MAX returns c exactly; level = 0 forces 0.
- The level used is the one sampled at stage 2.
- Fade FSM states: IDLE (level = LVL_MAX), FADE_OUT, DARK (level = 0), FADE_IN.
  - IDLE + fade_out_req → FADE_OUT.
  - DARK + fade_in_req → FADE_IN.
  - FADE_OUT/FADE_IN: a tick counter counts frame_tick_i. On each FADE_STEP-th tick, level decrements/increments by 1.
  - Reaching 0 → DARK; reaching LVL_MAX → IDLE.
  - fade_in_req during FADE_OUT reverses to FADE_IN from the current level; symmetric for fade_out_req during FADE_IN.
  - Both requests in the same cycle: fade_out wins in IDLE/FADE_IN, fade_in wins in DARK/FADE_OUT.
  - Redundant requests are ignored.
  - The tick counter clears on every state change.
- Reset mid-fade returns to IDLE at full level immediately.

Optional Feature:
- Macro SPRITE_PAL_DEFAULT_LOAD_EN.
- With it: after reset deassert, a loader writes DEFAULT_PAL into every palette, one entry per cycle, over NUM_PAL*2**IDX_W cycles, with init_busy_o = 1 throughout.
  - External writes and reads are accepted, but reads return 0 with valid_o while init_busy_o = 1.
  - A loader write has priority over a same-cycle external write.
- Without it: no loader, init_busy_o = 0.

Decomposition:
- Package sprite_pal_pkg: rgb_t struct typedef, DEFAULT_PAL 16-entry constant, and the fade_state_e enum.
- Sub-module sprite_pal_fade: fade FSM, tick counter and level register. Main block: RAM, forwarding, pipeline, scaling and loader.

Test Plan:
- Write pal1/idx3 = 0x063, then read pal1/idx3 → valid_o at +2 cycles, rgb = 0,6,3, transparent_o = 0. Read idx0 → transparent_o = 1.
- Back-to-back reads on 4 consecutive cycles → 4 consecutive valid_o with matching colours. Write and read the same entry in the same cycle → forwarded new value.
- FADE_STEP = 2, fade_out_req, 30 frame ticks → level 15→0 stepping every 2 ticks, then DARK with fade_busy_o = 0. Colour 0xF00 reads as 0x000.
- During FADE_OUT at level 9, assert fade_in_req → FADE_IN, level 10 after 2 ticks. At level 7, colour r = 0xA reads (0xA*8)>>4 = 5.
- Reset_n low mid-fade and mid-pipeline → outputs 0, level 15, valid_o 0 immediately (asynchronous).
- With SPRITE_PAL_DEFAULT_LOAD_EN, NUM_PAL = 4 → init_busy_o high for 64 cycles. Afterwards, any pal/idx2 reads 0x875.
